// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg: shared types for the Z80 bus-slave memory and its trace FIFO.
package z80_bus_pkg;
  localparam int TRACE_W = 25;
  typedef enum logic [1:0] {CYC_NONE, CYC_MEM, CYC_IO, CYC_INTA} cyc_kind_e;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_e;
  typedef struct packed {
    logic        is_io;
    logic [15:0] addr;
    logic [7:0]  data;
  } trace_t;
  // Refresh hides everything; INTA wins over IO because both pull iorq_n low.
  function automatic cyc_kind_e classify(input logic mreq_n, input logic iorq_n, input logic rd_n,
                                         input logic wr_n, input logic m1_n, input logic rfsh_n);
    return !rfsh_n ? CYC_NONE :
           (!iorq_n && !m1_n) ? CYC_INTA :
           (!mreq_n && (!rd_n || !wr_n)) ? CYC_MEM :
           (!iorq_n && (!rd_n || !wr_n)) ? CYC_IO : CYC_NONE;
  endfunction
endpackage

// File: rtl/z80_trace_fifo.sv
// z80_trace_fifo: write-trace FIFO with sticky overflow; a pop frees room for a same-edge push.
module z80_trace_fifo
  import z80_bus_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push,
  input  logic   pop,
  input  trace_t din,
  output trace_t head,
  output logic   empty,
  output logic   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  trace_t q [DEPTH];
  logic [AW:0] wp, rp;
  logic full, do_pop, do_push;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = q[rp[AW-1:0]];
  always_ff @(negedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wp <= wp + ONE;
      if (do_pop) rp <= rp + ONE;
      if (push && !do_push) overflow <= 1'b1;
    end
  always_ff @(negedge clk)
    if (do_push) q[wp[AW-1:0]] <= din;
endmodule

// File: rtl/z80_bus_slave_mem.sv
// z80_bus_slave_mem: Z80 bus-slave memory/IO responder with wait states, INTA vector,
// single-commit writes, write trace and a backdoor port. All state moves on the falling edge.
module z80_bus_slave_mem
  import z80_bus_pkg::*;
#(
  parameter int          ADDR_W      = 16,
  parameter bit          IO_SHARED   = 1'b1,
  parameter logic [7:0]  IO_PAGE     = 8'h10,
  parameter int          MEM_WAIT    = 0,
  parameter int          IO_WAIT     = 0,
  parameter logic [7:0]  INT_VECTOR  = 8'hFF,
  parameter int          TRACE_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [15:0]        a,
  input  logic [7:0]         dout,
  output logic [7:0]         di,
  input  logic               mreq_n,
  input  logic               iorq_n,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic               m1_n,
  input  logic               rfsh_n,
  output logic               wait_n,
  input  logic               trace_pop,
  output logic               trace_valid,
  output logic [TRACE_W-1:0] trace_entry,
  output logic               trace_overflow,
  input  logic               bd_we,
  input  logic [ADDR_W-1:0]  bd_addr,
  input  logic [7:0]         bd_wdata,
  output logic [7:0]         bd_rdata,
  output logic               bd_collide
);
  localparam logic [3:0] MW = 4'(MEM_WAIT);
  localparam logic [3:0] IW = 4'(IO_WAIT);
  logic [7:0] mem [2**ADDR_W];
  logic [7:0] io_mem [256];
  cyc_kind_e kind;
  state_e state;
  logic [3:0] cnt, nwait;
  logic is_io, io_sep, active, commit, fifo_empty;
  logic [15:0] addr16;
  logic [ADDR_W-1:0] maddr;
  logic [7:0] rdata;
  trace_t entry, head;
  assign kind = classify(mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n);
  assign is_io = kind == CYC_IO;
  assign active = kind == CYC_MEM || is_io;
  assign io_sep = is_io && !IO_SHARED;
  assign nwait = is_io ? IW : MW;
  assign addr16 = !is_io ? a : IO_SHARED ? {IO_PAGE, a[7:0]} : {8'h00, a[7:0]};
  assign maddr = addr16[ADDR_W-1:0];
  assign rdata = io_sep ? io_mem[a[7:0]] : mem[maddr];
  assign commit = state == S_ACCESS && active && !wr_n;
  assign entry = '{is_io: is_io, addr: io_sep ? addr16 : 16'(maddr), data: dout};
  assign bd_rdata = mem[bd_addr];
  assign trace_valid = !fifo_empty;
  assign trace_entry = head;
  always_ff @(negedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      cnt <= '0;
      wait_n <= 1'b1;
      di <= 8'h00;
      bd_collide <= 1'b0;
    end else begin
      bd_collide <= bd_we && commit && !io_sep && bd_addr == maddr;
      case (state)
        S_IDLE:
          if (kind == CYC_INTA) di <= INT_VECTOR;
          else if (active) begin
            cnt <= nwait - 4'd1;
            wait_n <= nwait == 4'd0;
            state <= nwait == 4'd0 ? S_ACCESS : S_WAIT;
          end
        S_WAIT:
          if (mreq_n && iorq_n) begin
            wait_n <= 1'b1;
            state <= S_IDLE;
          end else if (cnt == 4'd0) begin
            wait_n <= 1'b1;
            state <= S_ACCESS;
          end else cnt <= cnt - 4'd1;
        S_ACCESS:
          if (mreq_n && iorq_n) state <= S_IDLE;
          else if (commit) state <= S_DONE;
          else if (active) di <= rdata;
        S_DONE:
          if (mreq_n && iorq_n) state <= S_IDLE;
      endcase
    end
  // Bus write is ordered last so it wins a same-address backdoor write.
  always_ff @(negedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_wdata;
    if (commit && !io_sep) mem[maddr] <= dout;
    if (commit && io_sep) io_mem[a[7:0]] <= dout;
  end
  z80_trace_fifo #(.DEPTH(TRACE_DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(commit),
    .pop(trace_pop),
    .din(entry),
    .head(head),
    .empty(fifo_empty),
    .overflow(trace_overflow)
  );
endmodule
